// File: rtl/fft_bitrev_buffer_pkg.sv
// Shared definitions for the FFT input reorder buffer:
// default geometry, bank state encodings and the bit-reverse helper.
package fft_bitrev_buffer_pkg;

    localparam int FFT_N_POINTS = 8;
    localparam int FFT_LOG2N    = 3;
    localparam int FFT_DATA_W   = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Reverse the low 'width' bits of idx; bits above width are dropped.
    function automatic int bitrev(input int idx, input int width);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = (r << 1) | ((idx >> i) & 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_buffer_pp_bank.sv
// One ping-pong bank: N x DATA_W storage with a synchronous write port
// and an asynchronous read port so the reorder read needs no extra cycle.
module fft_bitrev_buffer_pp_bank
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int LOG2N    = FFT_LOG2N,
    parameter int DATA_W   = FFT_DATA_W
) (
    input  logic              sys_clk,
    input  logic              we,
    input  logic [LOG2N-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LOG2N-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [N_POINTS];

    // Sample storage; contents need no reset since bank state gates reads.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Natural-to-bit-reversed reorder buffer feeding the radix-2 DIT FFT core.
// Optional framing check on in_last is enabled by defining FFT_FRAME_CHK_EN.
module fft_bitrev_buffer
    import fft_bitrev_buffer_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int LOG2N    = FFT_LOG2N,
    parameter int DATA_W   = FFT_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              frame_err
);

    localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N_POINTS - 1);

    bank_state_e       bank_st [2];
    logic              wr_bank;
    logic              rd_bank;
    logic [LOG2N-1:0]  wr_cnt;
    logic [LOG2N-1:0]  rd_cnt;
    logic [LOG2N-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data;
    logic              wr_fire;
    logic              wr_en0;
    logic              wr_en1;
    logic              rd_avail;
    logic              out_load;
    logic              rd_fire;

    assign in_ready = !sys_rst &&
                      (bank_st[wr_bank] == BANK_EMPTY ||
                       bank_st[wr_bank] == BANK_FILLING);
    assign wr_fire  = in_valid && in_ready;
    assign wr_en0   = wr_fire && !wr_bank;
    assign wr_en1   = wr_fire && wr_bank;

    assign rd_avail = bank_st[rd_bank] == BANK_FULL ||
                      bank_st[rd_bank] == BANK_DRAINING;
    assign out_load = !out_valid || out_ready;
    assign rd_fire  = rd_avail && out_load;
    assign rd_addr  = LOG2N'(bitrev(int'(rd_cnt), LOG2N));
    assign rd_data  = rd_bank ? rd_data1 : rd_data0;

    fft_bitrev_buffer_pp_bank #(
        .N_POINTS (N_POINTS),
        .LOG2N    (LOG2N),
        .DATA_W   (DATA_W)
    ) u_bank0 (
        .sys_clk  (sys_clk),
        .we       (wr_en0),
        .waddr    (wr_cnt),
        .wdata    (in_data),
        .raddr    (rd_addr),
        .rdata    (rd_data0)
    );

    fft_bitrev_buffer_pp_bank #(
        .N_POINTS (N_POINTS),
        .LOG2N    (LOG2N),
        .DATA_W   (DATA_W)
    ) u_bank1 (
        .sys_clk  (sys_clk),
        .we       (wr_en1),
        .waddr    (wr_cnt),
        .wdata    (in_data),
        .raddr    (rd_addr),
        .rdata    (rd_data1)
    );

    // Write pointer: natural-order index, switches bank after the last sample.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            if (wr_cnt == CNT_MAX) begin
                wr_cnt  <= '0;
                wr_bank <= !wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Read pointer: advances on every output register load.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_fire) begin
            if (rd_cnt == CNT_MAX) begin
                rd_cnt  <= '0;
                rd_bank <= !rd_bank;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Bank lifecycle; a write and a read never target the same bank at once.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
        end else begin
            if (wr_fire) begin
                bank_st[wr_bank] <= (wr_cnt == CNT_MAX) ?
                                    BANK_FULL : BANK_FILLING;
            end
            if (rd_fire) begin
                bank_st[rd_bank] <= (rd_cnt == CNT_MAX) ?
                                    BANK_EMPTY : BANK_DRAINING;
            end
        end
    end

    // Output register: holds while the core stalls, refills when free.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (out_load) begin
            out_valid <= rd_avail;
            if (rd_avail) begin
                out_data  <= rd_data;
                out_first <= rd_cnt == '0;
                out_last  <= rd_cnt == CNT_MAX;
            end else begin
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef FFT_FRAME_CHK_EN
    // Sticky framing check: in_last must coincide with the final write index.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_err <= 1'b0;
        end else if (wr_fire && (in_last != (wr_cnt == CNT_MAX))) begin
            frame_err <= 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign frame_err      = 1'b0;
`endif

endmodule
